// File: rtl/ooo_pkg.sv
// ooo_pkg - shared types for the decode/rename boundary of the out-of-order core.
//
// dr_payload_t is the decoded-instruction record carried by dr_queue. Its
// natural width is DR_PAYLOAD_W (93 bits); integration pads it to
// DR_QUEUE_W (96) so the queue storage stays on a byte-friendly width.
package ooo_pkg;

  typedef struct packed {
    logic [31:0] pc_addr;
    logic [31:0] imm;
    logic        branch;
    logic        mem_read;
    logic [1:0]  write_data;
    logic [1:0]  alu_op;
    logic        mem_write;
    logic        alu_src_imm;
    logic        reg_write;
    logic        alu_src_pc;
    logic        jump;
    logic [2:0]  load_size;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } dr_payload_t;

  localparam int DR_PAYLOAD_W = $bits(dr_payload_t);
  localparam int DR_QUEUE_W   = 96;

endpackage

// File: rtl/dr_queue_ptr.sv
// dr_queue_ptr - circular index register for dr_queue.
//
// Increments by one on inc and wraps from DEPTH-1 back to 0 by explicit
// compare, so DEPTH need not be a power of two. clear has the same effect as
// reset and wins over inc.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset (pointer -> 0)
//   clear  synchronous clear (pointer -> 0), used for flush
//   inc    advance pointer this cycle
//   ptr    current index, 0..DEPTH-1
module dr_queue_ptr
  import ooo_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    end
  end

endmodule

// File: rtl/dr_queue.sv
// dr_queue - elastic FIFO between decode and rename.
//
// Holds up to DEPTH decoded-instruction payloads with valid/ready handshakes
// on both sides. in_ready depends on registered occupancy only, so rename
// back-pressure never forms a combinational path into decode. flush empties
// the queue at the next edge and discards any push/pop of the flush cycle.
//
// Build option: define DR_QUEUE_BYPASS_EN to let a payload arriving at an
// empty queue appear on out_data in the same cycle (and pass straight through
// without being stored when out_ready is high). Without it, latency from
// push to out_valid is exactly one cycle.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   flush               mispredict redirect, empties the queue
//   in_valid/in_ready   decode-side handshake, in_data payload
//   out_valid/out_ready rename-side handshake, out_data head payload (0 when invalid)
//   count               occupancy 0..DEPTH
//   full, empty         count == DEPTH, count == 0
module dr_queue
  import ooo_pkg::*;
#(
  parameter  int WIDTH = DR_QUEUE_W,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push;
  logic             pop;
  logic             byp_vld;
  logic             byp_take;
  logic             wr_en;
  logic             rd_en;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full;

`ifdef DR_QUEUE_BYPASS_EN
  // An empty queue presents the incoming payload directly; flush kills it.
  assign byp_vld  = empty && in_valid && !flush;
  assign byp_take = byp_vld && out_ready;
  assign out_data = !empty ? mem[rd_ptr] : (byp_vld ? in_data : '0);
`else
  assign byp_vld  = 1'b0;
  assign byp_take = 1'b0;
  assign out_data = !empty ? mem[rd_ptr] : '0;
`endif

  assign out_valid = !empty || byp_vld;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Storage-side events. A bypassed transfer is both a push and a pop but
  // touches neither the array nor the pointers.
  assign wr_en = push && !byp_take && !flush;
  assign rd_en = pop && !empty && !flush;

  dr_queue_ptr #(.DEPTH(DEPTH), .PW(PW)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .inc   (wr_en),
    .ptr   (wr_ptr)
  );

  dr_queue_ptr #(.DEPTH(DEPTH), .PW(PW)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .inc   (rd_en),
    .ptr   (rd_ptr)
  );

  // Payload storage is deliberately not reset; count/pointers qualify it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count <= '0;
    end else begin
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Occupancy implied by the pointers; a full queue has equal pointers.
  int ptr_gap;
  assign ptr_gap = (int'(wr_ptr) - int'(rd_ptr) + DEPTH) % DEPTH;

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (int'(count) <= DEPTH);
      assert (!(wr_en && full));
      assert (!(rd_en && empty));
      assert (ptr_gap == (int'(count) % DEPTH));
    end
  end

endmodule

// File: tb/tb_dr_queue.sv
// tb_dr_queue - scoreboard bench for dr_queue.
//
// Two instances share all inputs: DEPTH=4 and DEPTH=3 (non-power-of-two
// wrap), both WIDTH=8. A queue model per instance holds the expected
// contents; expected pushes are queued when stimulus is driven and the head
// is compared against out_data whenever the DUT presents a valid entry.
module tb_dr_queue;

`ifdef DR_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       flush;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;

  logic       a_in_ready, a_out_valid, a_full, a_empty;
  logic [7:0] a_out_data;
  logic [2:0] a_count;
  logic       b_in_ready, b_out_valid, b_full, b_empty;
  logic [7:0] b_out_data;
  logic [1:0] b_count;

  int total = 0;
  int bad   = 0;

  logic [7:0] q4[$];
  logic [7:0] q3[$];

  always #5 clk = ~clk;

  dr_queue #(.WIDTH(8), .DEPTH(4)) u_dut_a (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (a_in_ready),
    .in_data   (in_data),
    .out_valid (a_out_valid),
    .out_ready (out_ready),
    .out_data  (a_out_data),
    .count     (a_count),
    .full      (a_full),
    .empty     (a_empty)
  );

  dr_queue #(.WIDTH(8), .DEPTH(3)) u_dut_b (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (b_in_ready),
    .in_data   (in_data),
    .out_valid (b_out_valid),
    .out_ready (out_ready),
    .out_data  (b_out_data),
    .count     (b_count),
    .full      (b_full),
    .empty     (b_empty)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic chk_dut(input string p, input int dep, input int sz, input logic [7:0] head,
                         input logic iv, input logic [7:0] d, input logic fl,
                         input logic [31:0] cnt, input logic fu, input logic em,
                         input logic ir, input logic ov, input logic [7:0] od);
    logic       exp_ov;
    logic [7:0] exp_od;
    exp_ov = (sz > 0);
    exp_od = (sz > 0) ? head : 8'h00;
    if (BYP && sz == 0 && iv && !fl) begin
      exp_ov = 1'b1;
      exp_od = d;
    end
    check({p, "_count"},     cnt,          32'(sz));
    check({p, "_full"},      32'(fu),      32'(sz == dep));
    check({p, "_empty"},     32'(em),      32'(sz == 0));
    check({p, "_in_ready"},  32'(ir),      32'(sz < dep));
    check({p, "_out_valid"}, 32'(ov),      32'(exp_ov));
    check({p, "_out_data"},  32'(od),      32'(exp_od));
  endtask

  // One clock cycle: drive, settle, compare, advance the models, clock.
  task automatic cyc(input logic iv, input logic [7:0] d, input logic ordy, input logic fl);
    bit psh, pp;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    #1;
    chk_dut("a", 4, q4.size(), (q4.size() > 0) ? q4[0] : 8'h00, iv, d, fl,
            32'(a_count), a_full, a_empty, a_in_ready, a_out_valid, a_out_data);
    chk_dut("b", 3, q3.size(), (q3.size() > 0) ? q3[0] : 8'h00, iv, d, fl,
            32'(b_count), b_full, b_empty, b_in_ready, b_out_valid, b_out_data);
    if (fl) begin
      q4.delete();
    end else if (!(BYP && q4.size() == 0 && iv && ordy)) begin
      psh = iv && (q4.size() < 4);
      pp  = (q4.size() > 0) && ordy;
      if (pp)  void'(q4.pop_front());
      if (psh) q4.push_back(d);
    end
    if (fl) begin
      q3.delete();
    end else if (!(BYP && q3.size() == 0 && iv && ordy)) begin
      psh = iv && (q3.size() < 3);
      pp  = (q3.size() > 0) && ordy;
      if (pp)  void'(q3.pop_front());
      if (psh) q3.push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b0;
    q4.delete();
    q3.delete();
  endtask

  initial begin
    do_reset(2);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);

    // Fill with rename stalled; head must hold 0x11.
    for (int i = 1; i <= 4; i++) cyc(1'b1, 8'(8'h11 * i), 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);

    // Drain in order, then empty with gated data.
    repeat (4) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);

    // Streaming push+pop across pointer wrap.
    for (int i = 1; i <= 10; i++) cyc(1'b1, 8'(i), 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);

    // Push attempt while full together with a pop.
    for (int i = 1; i <= 4; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    cyc(1'b1, 8'h55, 1'b1, 1'b0);
    cyc(1'b1, 8'h55, 1'b0, 1'b0);
    repeat (5) cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // Flush discards the same-cycle push and pop.
    for (int i = 1; i <= 3; i++) cyc(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    cyc(1'b1, 8'h99, 1'b1, 1'b1);
    repeat (2) cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // Push into an empty queue with rename ready (bypass or 1-cycle latency).
    cyc(1'b1, 8'h7E, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);

    // Reset mid-operation.
    cyc(1'b1, 8'hA1, 1'b0, 1'b0);
    cyc(1'b1, 8'hA2, 1'b0, 1'b0);
    do_reset(1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 200; i++) begin
      cyc(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
          1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
    end
    repeat (5) cyc(1'b0, 8'h00, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
